// File: rtl/ifetch_queue.sv
// Instruction fetch stage: one outstanding icache request feeding a circular
// {pc, inst} queue that the decoder drains through a valid/ready handshake.
module ifetch_queue #(
    parameter int                  ADDR_WIDTH  = 32,
    parameter int                  INST_WIDTH  = 32,
    parameter int                  QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [2:0]          CTRL_OPC    = 3'b110
) (
    input  logic                           clk,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic                           cache_rdy,
    input  logic [INST_WIDTH-1:0]          inst_in,
    output logic [ADDR_WIDTH-1:0]          next_PC,
    output logic                           next_inst,
    input  logic                           flush,
    input  logic [ADDR_WIDTH-1:0]          rob2if,
    input  logic                           alu2if_cont,
    input  logic [ADDR_WIDTH-1:0]          alu2if,
    input  logic                           decUpd,
    input  logic [ADDR_WIDTH-1:0]          dec2if,
    output logic                           if2dec,
    input  logic                           dec_ready,
    output logic [INST_WIDTH-1:0]          inst_out,
    output logic [ADDR_WIDTH-1:0]          pc_out,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   pending_q, pending_d;
    logic                   drop_q, drop_d;
    logic [PW-1:0]          head_q, head_d;
    logic [PW-1:0]          tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;

    logic [ADDR_WIDTH-1:0]  pc_mem   [QUEUE_DEPTH];
    logic [INST_WIDTH-1:0]  inst_mem [QUEUE_DEPTH];

    logic                   resp;
    logic                   enq;
    logic                   deq;
    logic                   is_ctrl;
    logic [CW:0]            occupancy;

    // An outstanding request reserves a queue slot so its response always fits.
    assign occupancy   = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
    assign next_inst   = (state_q == RUN) && (occupancy < (CW+1)'(QUEUE_DEPTH)) && !flush;
    assign next_PC     = pc_q;
    assign queue_count = count_q;

    assign resp    = cache_rdy && pending_q;
    assign is_ctrl = (inst_in[6:4] == CTRL_OPC);
    assign enq     = resp && !drop_q && !flush;
    assign if2dec  = (count_q != '0);
    assign deq     = if2dec && dec_ready && !flush;

    assign inst_out = if2dec ? inst_mem[head_q] : '0;
    assign pc_out   = if2dec ? pc_mem[head_q]   : '0;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        drop_d    = drop_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (flush) begin
            // A request still in flight must have its late response discarded.
            state_d   = RUN;
            pc_d      = rob2if;
            pending_d = pending_q && !cache_rdy;
            drop_d    = pending_q && !cache_rdy;
            head_d    = tail_q;
            count_d   = '0;
        end else begin
            if (resp) begin
                pending_d = 1'b0;
                if (drop_q) begin
                    drop_d = 1'b0;
                end else begin
                    pc_d = pc_q + ADDR_WIDTH'(4);
                    if (is_ctrl)
                        state_d = BR_WAIT;
                end
            end else if (next_inst) begin
                pending_d = 1'b1;
            end

            if (state_q == BR_WAIT) begin
                if (alu2if_cont) begin
                    pc_d    = alu2if;
                    state_d = RUN;
                end else if (decUpd) begin
                    pc_d    = dec2if;
                    state_d = RUN;
                end
            end

            head_d  = head_q + PW'(deq);
            tail_d  = tail_q + PW'(enq);
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            pending_q <= 1'b0;
            drop_q    <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (rdy_in && enq) begin
            pc_mem[tail_q]   <= pc_q;
            inst_mem[tail_q] <= inst_in;
        end
    end

endmodule
